// File: rtl/tb_hwpe_stream_package.sv
// Shared enums and constants for the HWPE-Stream bench components.
package tb_hwpe_stream_package;

  typedef enum logic [1:0] {
    FORCE    = 2'd0,
    RANDOM   = 2'd1,
    PERIODIC = 2'd2,
    NONE     = 2'd3
  } ready_mode_e;

  typedef enum logic [1:0] {
    INCR  = 2'd0,
    LFSR  = 2'd1,
    CONST = 2'd2,
    OFF   = 2'd3
  } check_mode_e;

  // Non-zero start value of the stall-draw generator.
  localparam logic [15:0] STALL_RNG_SEED = 16'hACE1;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream link: valid/ready handshake with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  // A beat transfers on a rising edge where valid and ready are both high; once valid
  // rises the source must hold valid, data and strb stable until that edge.
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/tb_hwpe_stream_ref_gen.sv
// Golden-sequence generator shared by stream producers and checkers.
module tb_hwpe_stream_ref_gen
  import tb_hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_POLY  = 32'h80200003
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  check_mode_e           mode_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] ref_o
);

  localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(LFSR_POLY);
  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] ref_next;

  // Galois form: shift right, fold the taps back in when a one falls out.
  always_comb begin
    ref_next = ref_o;
    if (advance_i) begin
      case (mode_i)
        INCR:    ref_next = ref_o + ONE;
        LFSR:    ref_next = ref_o[0] ? ((ref_o >> 1) ^ POLY) : (ref_o >> 1);
        default: ref_next = ref_o;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_o <= '0;
    end else if (clear_i) begin
      ref_o <= seed_i;
    end else begin
      ref_o <= ref_next;
    end
  end

endmodule

// File: rtl/tb_hwpe_stream_checking_receiver.sv
// Stream sink with selectable backpressure, beat counting, golden-data and protocol checks.
module tb_hwpe_stream_checking_receiver
  import tb_hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NB_BEATS     = 256,
  parameter real         PROB_STALL   = 0.0,
  parameter int unsigned STALL_PERIOD = 8,
  parameter int unsigned STALL_LEN    = 2,
  parameter logic [31:0] LFSR_POLY    = 32'h80200003,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [1:0]            ready_mode_i,
  input  logic [1:0]            check_mode_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  hwpe_stream_intf_stream.sink  push,
  output logic [CNT_WIDTH-1:0]  recv_count_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic                  proto_err_o,
  output logic [CNT_WIDTH-1:0]  first_err_idx_o,
  output logic                  done_o
);

  localparam int unsigned             STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned             PHASE_WIDTH = $clog2(STALL_PERIOD);
  localparam logic [PHASE_WIDTH-1:0]  PHASE_LAST  = PHASE_WIDTH'(STALL_PERIOD - 1);
  localparam logic [PHASE_WIDTH-1:0]  PHASE_OPEN  = PHASE_WIDTH'(STALL_LEN);
  localparam logic [PHASE_WIDTH-1:0]  PHASE_ONE   = PHASE_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    LAST_IDX    = CNT_WIDTH'(NB_BEATS - 1);
  // Stall probability scaled to the 0..1023 range of the draw.
  localparam logic [10:0]             STALL_THRESH = 11'($rtoi(PROB_STALL * 1024.0));

  ready_mode_e            ready_mode;
  check_mode_e            check_mode;
  logic                   hs;
  logic                   mismatch;
  logic                   proto_viol;
  logic                   last_beat;
  logic                   done_d;
  logic                   ready_d;
  logic                   stall_draw;
  logic                   ready_q;
  logic                   stalled_q;
  logic [DATA_WIDTH-1:0]  ref_data;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [STRB_WIDTH-1:0]  strb_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [15:0]            rng_q;

  assign ready_mode = ready_mode_e'(ready_mode_i);
  assign check_mode = check_mode_e'(check_mode_i);
  assign push.ready = ready_q;

  tb_hwpe_stream_ref_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_POLY  (LFSR_POLY)
  ) i_ref_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .seed_i    (seed_i),
    .mode_i    (check_mode),
    .advance_i (hs),
    .ref_o     (ref_data)
  );

  always_comb begin
    hs         = push.valid & ready_q;
    mismatch   = hs & (check_mode != OFF) &
                 ((push.data != ref_data) | (push.strb != '1));
    proto_viol = enable_i & stalled_q &
                 (~push.valid | (push.data != data_q) | (push.strb != strb_q));
    last_beat  = hs & (recv_count_o == LAST_IDX);
    done_d     = done_o | last_beat;
    stall_draw = ({1'b0, rng_q[9:0]} < STALL_THRESH);
    ready_d    = 1'b0;
    // Looking at done_d rather than done_o keeps the final beat from being followed by an extra one.
    if (enable_i && !done_d) begin
      case (ready_mode)
        FORCE:    ready_d = 1'b1;
        RANDOM:   ready_d = (push.valid | ~ready_q) ? ~stall_draw : 1'b1;
        PERIODIC: ready_d = (phase_q >= PHASE_OPEN);
        default:  ready_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q         <= 1'b0;
      recv_count_o    <= '0;
      err_count_o     <= '0;
      proto_err_o     <= 1'b0;
      first_err_idx_o <= '0;
      done_o          <= 1'b0;
      phase_q         <= '0;
      stalled_q       <= 1'b0;
      data_q          <= '0;
      strb_q          <= '0;
    end else if (clear_i) begin
      ready_q         <= 1'b0;
      recv_count_o    <= '0;
      err_count_o     <= '0;
      proto_err_o     <= 1'b0;
      first_err_idx_o <= '0;
      done_o          <= 1'b0;
      phase_q         <= '0;
      stalled_q       <= 1'b0;
      data_q          <= '0;
      strb_q          <= '0;
    end else begin
      ready_q   <= ready_d;
      done_o    <= done_d;
      phase_q   <= (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_ONE;
      stalled_q <= push.valid & ~ready_q;
      data_q    <= push.data;
      strb_q    <= push.strb;
      if (hs && (recv_count_o != CNT_MAX)) begin
        recv_count_o <= recv_count_o + CNT_ONE;
      end
      if (mismatch) begin
        if (err_count_o == '0) begin
          first_err_idx_o <= recv_count_o;
        end
        if (err_count_o != CNT_MAX) begin
          err_count_o <= err_count_o + CNT_ONE;
        end
      end
      if (proto_viol) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  // Free-running maximal-length LFSR (x^16+x^15+x^13+x^4+1) feeding the stall draw.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rng_q <= STALL_RNG_SEED;
    end else begin
      rng_q <= {rng_q[14:0], rng_q[15] ^ rng_q[14] ^ rng_q[12] ^ rng_q[3]};
    end
  end

endmodule
